// File: rtl/uart_echo_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_checker_if
// Description : FIFO-side port bundle between the echo checker and a uart.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_echo_checker_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;

    modport master (
        input  tx_full,
        input  rx_empty,
        input  r_data,
        output wr_uart,
        output w_data,
        output rd_uart
    );

    modport slave (
        output tx_full,
        output rx_empty,
        output r_data,
        input  wr_uart,
        input  w_data,
        input  rd_uart
    );
endinterface
`default_nettype wire

// File: rtl/uart_echo_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_checker
// Description : Sends a run of bytes through a uart and checks each echo is
//               byte+1. Optional macro UART_ECHO_LFSR_EN selects LFSR bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_checker #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             num_bytes,
    uart_echo_checker_if.master    uart,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [7:0]             last_rx
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_ECHO_LFSR_EN
    localparam logic [7:0] SEED = 8'h01;
`else
    localparam logic [7:0] SEED = 8'h00;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] next_tx(input logic [7:0] b);
`ifdef UART_ECHO_LFSR_EN
        // Fibonacci x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 into bit 0
        return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
`else
        return b + 8'd1;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         tx_q, tx_d;
    logic [8:0]         target_q, target_d;
    logic [8:0]         sent_q, sent_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         last_rx_q, last_rx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               wr_uart, rd_uart;
    logic [CNT_W-1:0]   err_sat;

    assign err_sat = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        target_d  = target_q;
        sent_d    = sent_q;
        timer_d   = timer_q;
        err_cnt_d = err_cnt_q;
        timeout_d = timeout_q;
        last_rx_d = last_rx_q;
        wr_uart   = 1'b0;
        rd_uart   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // num_bytes==0 maps to 256 via the ninth bit
                    target_d  = {(num_bytes == 8'd0), num_bytes};
                    sent_d    = 9'd0;
                    err_cnt_d = '0;
                    timeout_d = 1'b0;
                    tx_d      = SEED;
                    state_d   = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!uart.rx_empty) begin
                    rd_uart = 1'b1;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!uart.tx_full) begin
                    wr_uart = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A late echo still beats the timeout in the same cycle
                if (!uart.rx_empty) begin
                    rd_uart   = 1'b1;
                    last_rx_d = uart.r_data;
                    if (uart.r_data != 8'(tx_q + 8'd1)) begin
                        err_cnt_d = err_sat;
                    end
                    tx_d   = next_tx(tx_q);
                    sent_d = sent_q + 9'd1;
                    state_d = ((sent_q + 9'd1) == target_q) ? S_DONE : S_SEND;
                end else if (timer_q == TMR_LAST) begin
                    err_cnt_d = err_sat;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FLUSH) || (state_d == S_SEND) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_cnt_d == '0) && !timeout_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tx_q      <= SEED;
            target_q  <= 9'd0;
            sent_q    <= 9'd0;
            timer_q   <= '0;
            err_cnt_q <= '0;
            timeout_q <= 1'b0;
            last_rx_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            target_q  <= target_d;
            sent_q    <= sent_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
            timeout_q <= timeout_d;
            last_rx_q <= last_rx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign uart.wr_uart = wr_uart;
    assign uart.rd_uart = rd_uart;
    assign uart.w_data  = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign err_cnt      = err_cnt_q;
    assign last_rx      = last_rx_q;

endmodule
`default_nettype wire
